// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and load results into one registered register-file write per cycle.
// Optional REGFILE_WB_PERF_EN adds a saturating load-stall cycle counter.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int INDEX = 5,
    parameter int DEPTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  issue_in,
    input  logic [INDEX-1:0]      issue_rd_in,
    input  logic                  alu_valid_in,
    output logic                  alu_ready_out,
    input  logic [INDEX-1:0]      alu_rd_in,
    input  logic [WIDTH-1:0]      alu_data_in,
    input  logic                  ld_valid_in,
    output logic                  ld_ready_out,
    input  logic [INDEX-1:0]      ld_rd_in,
    input  logic [WIDTH-1:0]      ld_data_in,
    output logic                  we_out,
    output logic [INDEX-1:0]      address_w_out,
    output logic [WIDTH-1:0]      data_w_out,
    output logic [2**INDEX-1:0]   busy_out,
    output logic                  err_out
`ifdef REGFILE_WB_PERF_EN
   ,output logic [31:0]           ld_stall_cnt_out
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int NREG = 2**INDEX;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [INDEX-1:0] rd_mem [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic             we_q, we_d, err_q, err_d;
    logic [INDEX-1:0] address_w_q, address_w_d;
    logic [WIDTH-1:0] data_w_q, data_w_d;
    logic [NREG-1:0]  busy_q, busy_d, set_mask, clr_mask;
    logic             full, empty, alu_xfer, ld_xfer, pop, bypass, push, win, wr;
    logic [INDEX-1:0] win_rd;
    logic [WIDTH-1:0] win_data;

    assign full          = count_q == (PW+1)'(DEPTH);
    assign empty         = count_q == '0;
    assign alu_ready_out = !full;
    assign ld_ready_out  = !full;

    always_comb begin
        alu_xfer    = alu_valid_in && alu_ready_out;
        ld_xfer     = ld_valid_in && ld_ready_out;
        // A full FIFO blocks the load, so its head always wins then
        pop         = !ld_xfer && !empty;
        bypass      = !ld_xfer && empty && alu_xfer;
        push        = alu_xfer && !bypass;
        win         = pop || ld_xfer || bypass;
        win_rd      = pop ? rd_mem[rd_ptr_q] : ld_xfer ? ld_rd_in : alu_rd_in;
        win_data    = pop ? data_mem[rd_ptr_q] : ld_xfer ? ld_data_in : alu_data_in;
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = count_q + (PW+1)'(push) - (PW+1)'(pop);
        wr          = win && win_rd != '0;
        we_d        = wr;
        address_w_d = wr ? win_rd : address_w_q;
        data_w_d    = wr ? win_data : data_w_q;
        clr_mask    = wr ? NREG'(1) << win_rd : '0;
        set_mask    = (issue_in && issue_rd_in != '0) ? NREG'(1) << issue_rd_in : '0;
        busy_d      = (busy_q & ~clr_mask) | set_mask;
        err_d       = err_q || (|(set_mask & busy_q)) || (wr && !busy_q[win_rd]);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            we_q        <= 1'b0;
            address_w_q <= '0;
            data_w_q    <= '0;
            busy_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            we_q        <= we_d;
            address_w_q <= address_w_d;
            data_w_q    <= data_w_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= alu_rd_in;
            data_mem[wr_ptr_q] <= alu_data_in;
        end
    end

    assign we_out        = we_q;
    assign address_w_out = address_w_q;
    assign data_w_out    = data_w_q;
    assign busy_out      = busy_q;
    assign err_out       = err_q;

`ifdef REGFILE_WB_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = (ld_valid_in && !ld_ready_out && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign ld_stall_cnt_out = stall_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors with hand-computed expectations for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic [4:0]  issue_rd;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] busy;
    logic        err;
`ifdef REGFILE_WB_PERF_EN
    logic [31:0] stall_cnt;
`endif
    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter dut (
        .clk_in(clk), .rst_in(rst),
        .issue_in(issue), .issue_rd_in(issue_rd),
        .alu_valid_in(alu_valid), .alu_ready_out(alu_ready), .alu_rd_in(alu_rd), .alu_data_in(alu_data),
        .ld_valid_in(ld_valid), .ld_ready_out(ld_ready), .ld_rd_in(ld_rd), .ld_data_in(ld_data),
        .we_out(we), .address_w_out(addr), .data_w_out(wdata),
        .busy_out(busy), .err_out(err)
`ifdef REGFILE_WB_PERF_EN
       ,.ld_stall_cnt_out(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_issue(input logic [4:0] rd);
        issue = 1'b1;
        issue_rd = rd;
        tick();
        issue = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        issue = 0; issue_rd = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        tick();
        tick();
        check("rst_we", we, 0);
        check("rst_addr", addr, 0);
        check("rst_data", wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_ld_ready", ld_ready, 1);
        rst = 1'b0;
        tick();

        // bypass
        do_issue(5);
        check("byp_busy_set", busy, 32'h20);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        check("byp_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        check("byp_we", we, 1);
        check("byp_addr", addr, 5);
        check("byp_data", wdata, 32'hDEADBEEF);
        check("byp_busy_clr", busy, 0);
        tick();
        check("byp_we_drop", we, 0);

        // load priority
        do_issue(3);
        do_issue(4);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        ld_valid = 1; ld_rd = 4; ld_data = 32'h22;
        tick();
        alu_valid = 0; ld_valid = 0;
        check("pri_ld_we", we, 1);
        check("pri_ld_addr", addr, 4);
        check("pri_ld_data", wdata, 32'h22);
        check("pri_busy_mid", busy, 32'h8);
        tick();
        check("pri_alu_we", we, 1);
        check("pri_alu_addr", addr, 3);
        check("pri_alu_data", wdata, 32'h11);
        check("pri_busy_end", busy, 0);
        tick();
        check("pri_idle_we", we, 0);

        // full FIFO: loads win four times while ALU results pile up
        for (int r = 10; r <= 13; r++) do_issue(5'(r));
        for (int r = 20; r <= 24; r++) do_issue(5'(r));
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'h100 + 32'(10 + i);
            ld_valid = 1; ld_rd = 5'(20 + i); ld_data = 32'h200 + 32'(20 + i);
            check("full_fill_ld_ready", ld_ready, 1);
            tick();
            check("full_fill_addr", addr, 64'(20 + i));
        end
        alu_valid = 0;
        ld_rd = 24; ld_data = 32'h224;
        check("full_alu_ready", alu_ready, 0);
        check("full_ld_ready", ld_ready, 0);
        tick();
        check("full_head_addr", addr, 10);
        check("full_head_data", wdata, 32'h10A);
        check("full_ld_ready_back", ld_ready, 1);
        tick();
        ld_valid = 0;
        check("full_ld_addr", addr, 24);
        check("full_ld_data", wdata, 32'h224);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("full_drain_we", we, 1);
            check("full_drain_addr", addr, 64'(10 + i));
        end
        tick();
        check("full_idle_we", we, 0);
        check("full_busy", busy, 0);
        check("full_err", err, 0);
`ifdef REGFILE_WB_PERF_EN
        check("full_stall_cnt", stall_cnt, 1);
`endif

        // x0 result is consumed without a write
        do_issue(6);
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        check("x0_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        check("x0_we", we, 0);
        check("x0_busy", busy, 32'h40);
        check("x0_err", err, 0);

        // WAW issue error, sticky
        do_issue(7);
        check("waw_first", err, 0);
        do_issue(7);
        check("waw_err", err, 1);
        tick();
        tick();
        check("waw_sticky", err, 1);

        // async reset with two FIFO entries held
        do_issue(14); do_issue(15); do_issue(16); do_issue(17);
        alu_valid = 1; alu_rd = 14; alu_data = 32'h14;
        ld_valid = 1; ld_rd = 15; ld_data = 32'h15;
        tick();
        alu_rd = 16; alu_data = 32'h16;
        ld_rd = 17; ld_data = 32'h17;
        @(posedge clk);
        #1;
        check("arst_pre_addr", addr, 17);
        check("arst_pre_busy", busy, 32'h140C0);
        #1 rst = 1'b1;
        #1;
        check("arst_we", we, 0);
        check("arst_addr", addr, 0);
        check("arst_data", wdata, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        alu_valid = 0; ld_valid = 0;
        rst = 1'b0;
        check("arst_alu_ready", alu_ready, 1);
        tick();
        check("arst_idle_we", we, 0);

        // write to non-busy register after reset: bypass plus error
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        tick();
        alu_valid = 0;
        check("post_we", we, 1);
        check("post_addr", addr, 9);
        check("post_data", wdata, 32'h99);
        check("post_err", err, 1);
        tick();
        check("post_we_drop", we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
